// File: rtl/mux_piso_pkg.sv
// ---------------------------------------------------------------------------
// mux_piso_pkg
// Shared types, widths and helpers for the mux-driven PISO sequencer.
//   - state_e      : sequencer states (IDLE, SHIFT, PARITY)
//   - SEL_W/DATA_W : select and data widths
//   - sel_first/sel_last/sel_step : index helpers derived from LSB_FIRST
//   - parity_even  : even parity over a data word
// Optional feature macro used by the top: MUX_PISO_PARITY_EN
// ---------------------------------------------------------------------------
package mux_piso_pkg;

    localparam int SEL_W  = 3;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    // First index presented for a word.
    function automatic logic [SEL_W-1:0] sel_first(input bit lsb_first);
        return lsb_first ? 3'd0 : 3'd7;
    endfunction

    // Index of the final data bit of a word.
    function automatic logic [SEL_W-1:0] sel_last(input bit lsb_first);
        return lsb_first ? 3'd7 : 3'd0;
    endfunction

    // Per-cycle increment; 3'd7 is -1 modulo 8 for the MSB-first order.
    function automatic logic [SEL_W-1:0] sel_step(input bit lsb_first);
        return lsb_first ? 3'd1 : 3'd7;
    endfunction

    // Even parity: 1 when the word holds an odd number of ones.
    function automatic logic parity_even(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mux8X1.sv
// ---------------------------------------------------------------------------
// mux8X1
// Combinational 8:1 multiplexer.
//   in  [7:0] : data inputs
//   sel [2:0] : select
//   out       : in[sel]
// ---------------------------------------------------------------------------
module mux8X1 (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       out
);

    // Select one of eight inputs.
    always_comb begin
        out = 1'b0;
        case (sel)
            3'd0:    out = in[0];
            3'd1:    out = in[1];
            3'd2:    out = in[2];
            3'd3:    out = in[3];
            3'd4:    out = in[4];
            3'd5:    out = in[5];
            3'd6:    out = in[6];
            3'd7:    out = in[7];
            default: out = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_piso_sequencer.sv
// ---------------------------------------------------------------------------
// mux_piso_sequencer
// Loads an 8-bit word over valid/ready and steps the 8:1 mux select through
// all eight positions, one per clock, producing a framed serial stream.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : load handshake
//   in_data [7:0]       : word to serialise
//   sel [2:0]           : registered select to the 8:1 mux
//   ser_out             : current serial bit
//   ser_valid/ser_last  : stream framing
//   busy                : word in flight
// Parameter LSB_FIRST: 1 = bit 0 first (sel 0..7), 0 = bit 7 first (sel 7..0).
// Optional macro MUX_PISO_PARITY_EN: appends one even-parity bit per word.
// ---------------------------------------------------------------------------
module mux_piso_sequencer
    import mux_piso_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [SEL_W-1:0]  sel,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy
);

    localparam logic [SEL_W-1:0] SEL_FIRST = sel_first(LSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_LAST  = sel_last(LSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_STEP  = sel_step(LSB_FIRST);
`ifdef MUX_PISO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    state_e              r_state;
    logic [DATA_W-1:0]   r_data;
    logic [SEL_W-1:0]    r_sel;

    state_e              w_state_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic                w_accept;
    logic                w_mux_out;

    assign w_accept = in_valid & in_ready;
    assign sel      = r_sel;

    mux8X1 u_mux (
        .in  (r_data),
        .sel (r_sel),
        .out (w_mux_out)
    );

`ifdef MUX_PISO_PARITY_EN
    assign ser_out = (r_state == PARITY) ? parity_even(r_data) : w_mux_out;
`else
    assign ser_out = w_mux_out;
`endif

    // State, captured word and select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_data  <= 8'h00;
            r_sel   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Next-state logic: a handshake always (re)loads the word and restarts
    // the select at the first index; the counter itself never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_sel_nxt   = r_sel;
        if (w_accept) begin
            w_state_nxt = SHIFT;
            w_data_nxt  = in_data;
            w_sel_nxt   = SEL_FIRST;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                SHIFT: begin
                    if (r_sel == SEL_LAST) begin
                        // sel holds on the last bit; parity (if any) follows
                        w_state_nxt = PARITY_EN ? PARITY : IDLE;
                    end else begin
                        w_sel_nxt = r_sel + SEL_STEP;
                    end
                end
`ifdef MUX_PISO_PARITY_EN
                PARITY: begin
                    w_state_nxt = IDLE;
                end
`endif
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state and select.
    always_comb begin
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_last  = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                if ((r_sel == SEL_LAST) && !PARITY_EN) begin
                    in_ready = 1'b1;
                    ser_last = 1'b1;
                end else begin
                    in_ready = 1'b0;
                    ser_last = 1'b0;
                end
            end
`ifdef MUX_PISO_PARITY_EN
            PARITY: begin
                ser_valid = 1'b1;
                ser_last  = 1'b1;
                in_ready  = 1'b1;
            end
`endif
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_piso_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_piso_sequencer
// Directed bench with a scoreboard: two instances (LSB-first and MSB-first)
// share clock and reset. Expected stream entries {bit, last, sel} are pushed
// when a word is offered and popped whenever a DUT shows ser_valid.
// Works with and without MUX_PISO_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_mux_piso_sequencer;

`ifdef MUX_PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int W = PAR ? 9 : 8;

    logic       clk;
    logic       rst_n;
    logic       a_in_valid, a_in_ready, a_ser_out, a_ser_valid, a_ser_last, a_busy;
    logic [7:0] a_in_data;
    logic [2:0] a_sel;
    logic       b_in_valid, b_in_ready, b_ser_out, b_ser_valid, b_ser_last, b_busy;
    logic [7:0] b_in_data;
    logic [2:0] b_sel;

    int         n_checks;
    int         n_errors;
    logic [4:0] qa[$];
    logic [4:0] qb[$];

    mux_piso_sequencer #(.LSB_FIRST(1'b1)) u_dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .sel       (a_sel),
        .ser_out   (a_ser_out),
        .ser_valid (a_ser_valid),
        .ser_last  (a_ser_last),
        .busy      (a_busy)
    );

    mux_piso_sequencer #(.LSB_FIRST(1'b0)) u_dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .sel       (b_sel),
        .ser_out   (b_ser_out),
        .ser_valid (b_ser_valid),
        .ser_last  (b_ser_last),
        .busy      (b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected stream for one word: 8 data bits in select order, then parity.
    task automatic push_exp(input bit to_b, input bit lsb, input logic [7:0] w);
        logic [2:0] idx;
        logic [4:0] e;
        for (int k = 0; k < 8; k++) begin
            idx = lsb ? k[2:0] : 3'(7 - k);
            e   = {w[idx], (k == 7) && !PAR, idx};
            if (to_b) qb.push_back(e);
            else      qa.push_back(e);
        end
        if (PAR) begin
            e = {^w, 1'b1, (lsb ? 3'd7 : 3'd0)};
            if (to_b) qb.push_back(e);
            else      qa.push_back(e);
        end
    endtask

    // Advance one clock and score both instances #1 after the edge.
    task automatic tick();
        logic [4:0] e;
        @(posedge clk);
        #1;
        if (a_ser_valid) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_valid", 8'(a_ser_valid), 8'd0);
            end else begin
                e = qa.pop_front();
                chk("a_ser_out",  8'(a_ser_out),  8'(e[4]));
                chk("a_ser_last", 8'(a_ser_last), 8'(e[3]));
                chk("a_sel",      8'(a_sel),      8'(e[2:0]));
                chk("a_in_ready", 8'(a_in_ready), 8'(e[3]));
                chk("a_busy",     8'(a_busy),     8'd1);
            end
        end else begin
            chk("a_idle_busy",  8'(a_busy),     8'd0);
            chk("a_idle_ready", 8'(a_in_ready), 8'd1);
        end
        if (b_ser_valid) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_valid", 8'(b_ser_valid), 8'd0);
            end else begin
                e = qb.pop_front();
                chk("b_ser_out",  8'(b_ser_out),  8'(e[4]));
                chk("b_ser_last", 8'(b_ser_last), 8'(e[3]));
                chk("b_sel",      8'(b_sel),      8'(e[2:0]));
                chk("b_in_ready", 8'(b_in_ready), 8'(e[3]));
                chk("b_busy",     8'(b_busy),     8'd1);
            end
        end else begin
            chk("b_idle_busy",  8'(b_busy),     8'd0);
            chk("b_idle_ready", 8'(b_in_ready), 8'd1);
        end
    endtask

    // One isolated word on instance A (use_b=0) or B (use_b=1).
    task automatic run_word(input bit use_b, input logic [7:0] w);
        if (use_b) begin
            chk("b_ready_before", 8'(b_in_ready), 8'd1);
            b_in_valid = 1'b1;
            b_in_data  = w;
            push_exp(1'b1, 1'b0, w);
        end else begin
            chk("a_ready_before", 8'(a_in_ready), 8'd1);
            a_in_valid = 1'b1;
            a_in_data  = w;
            push_exp(1'b0, 1'b1, w);
        end
        tick();
        chk("first_bit_latency", 8'(use_b ? b_ser_valid : a_ser_valid), 8'd1);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        repeat (W - 1) tick();
        tick();
        chk("idle_after_word", 8'(use_b ? b_ser_valid : a_ser_valid), 8'd0);
        chk("queue_drained", 8'(use_b ? qb.size() : qa.size()), 8'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        a_in_valid = 1'b0;
        a_in_data  = 8'h00;
        b_in_valid = 1'b0;
        b_in_data  = 8'h00;

        // Reset state.
        #1;
        chk("rst_a_sel",       8'(a_sel),       8'd0);
        chk("rst_a_ser_valid", 8'(a_ser_valid), 8'd0);
        chk("rst_a_ser_last",  8'(a_ser_last),  8'd0);
        chk("rst_a_busy",      8'(a_busy),      8'd0);
        chk("rst_a_ser_out",   8'(a_ser_out),   8'd0);
        chk("rst_b_sel",       8'(b_sel),       8'd0);
        chk("rst_b_busy",      8'(b_busy),      8'd0);
        #20;
        rst_n = 1'b1;
        tick();

        // Single words: LSB-first, MSB-first, parity patterns.
        run_word(1'b0, 8'b1000_0001);
        run_word(1'b1, 8'hA5);
        run_word(1'b0, 8'h07);
        run_word(1'b0, 8'h03);
        run_word(1'b1, 8'h3C);

        // Back-to-back FF then 00 with in_valid held high: no bubble.
        chk("b2b_ready_before", 8'(a_in_ready), 8'd1);
        a_in_valid = 1'b1;
        a_in_data  = 8'hFF;
        push_exp(1'b0, 1'b1, 8'hFF);
        push_exp(1'b0, 1'b1, 8'h00);
        for (int i = 1; i <= 2 * W; i++) begin
            tick();
            chk("b2b_valid", 8'(a_ser_valid), 8'd1);
            if (i == 1)     a_in_data  = 8'h00;
            if (i == W + 1) a_in_valid = 1'b0;
        end
        tick();
        chk("b2b_idle", 8'(a_ser_valid), 8'd0);
        chk("b2b_drained", 8'(qa.size()), 8'd0);

        // Hold-off: in_data churns while busy; only the last-bit cycle loads.
        a_in_valid = 1'b1;
        a_in_data  = 8'h3C;
        push_exp(1'b0, 1'b1, 8'h3C);
        push_exp(1'b0, 1'b1, 8'hC6);
        for (int i = 1; i <= 2 * W; i++) begin
            tick();
            chk("holdoff_valid", 8'(a_ser_valid), 8'd1);
            if (i < W)      a_in_data  = 8'($urandom);
            if (i == W)     a_in_data  = 8'hC6;
            if (i == W + 1) a_in_valid = 1'b0;
        end
        tick();
        chk("holdoff_idle", 8'(a_ser_valid), 8'd0);
        chk("holdoff_drained", 8'(qa.size()), 8'd0);

        // Asynchronous reset in the middle of a word.
        a_in_valid = 1'b1;
        a_in_data  = 8'hA5;
        push_exp(1'b0, 1'b1, 8'hA5);
        tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ser_valid", 8'(a_ser_valid), 8'd0);
        chk("midrst_busy",      8'(a_busy),      8'd0);
        chk("midrst_sel",       8'(a_sel),       8'd0);
        chk("midrst_ser_last",  8'(a_ser_last),  8'd0);
        chk("midrst_ser_out",   8'(a_ser_out),   8'd0);
        chk("midrst_in_ready",  8'(a_in_ready),  8'd1);
        qa.delete();
        #2;
        rst_n = 1'b1;
        repeat (W + 2) tick();
        chk("postrst_ready", 8'(a_in_ready), 8'd1);
        run_word(1'b0, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_piso_sequencer.md
Name: mux_piso_sequencer

Overview:
- Upstream driver for the 8:1 mux stage. Accepts an 8-bit word over a valid/ready handshake and steps the 3-bit select through all eight positions, one per clock.
- Presents the mux-selected bit as a serial stream with valid/last framing.
- Turns the combinational 8:1 mux into a parallel-in/serial-out converter for downstream serial logic.

Parameters:
- LSB_FIRST, 1, 1: sel counts 0→7 (bit 0 first); 0: sel counts 7→0 (bit 7 first)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data holds a word to load
- in_ready  output  1  block can accept a word this cycle
- in_data  input  8  parallel word to serialise
- sel  output  3  select driven to the 8:1 mux (registered)
- ser_out  output  1  current serial bit, i.e. captured word bit at index sel
- ser_valid  output  1  ser_out is a valid stream bit
- ser_last  output  1  final bit of the current word
- busy  output  1  word in flight (state != IDLE)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- States: IDLE, SHIFT (plus PARITY when the optional feature is compiled in).
- Reset (rst_n low, any state, immediately, no clock needed):
  - state=IDLE, data_reg=8'h00, sel=3'd0, ser_valid=0, ser_last=0, busy=0.
  - Any word in flight is discarded; no partial stream resumes.
- IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid&&in_ready: data_reg<=in_data; sel<=first index (0 if LSB_FIRST, else 7); state<=SHIFT.
- SHIFT:
  - ser_valid=1; ser_out=data_reg[sel], produced combinationally by the mux sub-module.
  - Each cycle sel advances by one (+1 if LSB_FIRST, else −1).
  - Latency: the first bit appears the cycle after the handshake. Exactly 8 SHIFT cycles per word.
- Last data bit (sel==7 for LSB_FIRST, sel==0 otherwise):
  - ser_last=1, in_ready=1.
  - If in_valid is high: load the new word, reset sel to the first index, stay in SHIFT. Back-to-back words have no bubble.
  - Otherwise: state<=IDLE, sel holds its value.
- in_ready=0 in SHIFT except on the last-bit cycle. in_data is ignored when in_ready=0. data_reg is stable for the whole word.
- sel is 3 bits with no wrap. The sequencer explicitly reloads the first index; the counter never wraps 7→0 on its own.
- ser_out in IDLE = data_reg[sel]. It is a don't-care for consumers but deterministic: 0 after reset.
- busy = (state != IDLE).

Optional Feature:
- Macro: MUX_PISO_PARITY_EN.
- Defined:
  - After the last data bit, one PARITY cycle: ser_out=^data_reg (even parity), ser_valid=1, ser_last=1, sel held.
  - ser_last is not asserted on bit 7/0. in_ready=1 only in the PARITY cycle, with the same back-to-back rule.
  - 9 cycles per word.
- Undefined: no PARITY state, 8 cycles per word, behaviour as above.

Decomposition:
- Package mux_piso_pkg:
  - state enum (IDLE, SHIFT, PARITY)
  - SEL_W=3, DATA_W=8
  - SEL_FIRST/SEL_LAST localparams derived from LSB_FIRST
- Sub-module: the existing 8:1 mux module (mux8X1: in[7:0], sel[2:0], out) is instantiated to generate ser_out from data_reg and sel.
- Sequencer FSM and select counter live in the top module.

Test Plan:
- Reset mid-word: load 8'hA5, drop rst_n after 3 bits (async, between edges) → outputs are reset values immediately; after release in_ready=1 and no stale bits appear.
- Single word, LSB_FIRST=1: in_data=8'b1000_0001, one handshake → ser_out 1,0,0,0,0,0,0,1 with sel 0..7, ser_last only with sel=7, then IDLE with ser_valid=0.
- MSB_FIRST (LSB_FIRST=0): in_data=8'hA5 → ser_out 1,0,1,0,0,1,0,1 with sel 7..0; ser_last on sel=0.
- Back-to-back: in_valid held high with 8'hFF then 8'h00 → 16 consecutive ser_valid cycles, pattern 8×1 then 8×0, ser_last at cycles 8 and 16, in_ready high only at those cycles.
- Handshake hold-off: in_valid=1 with in_data changing every cycle during SHIFT → captured word unchanged; a new load occurs only on the last-bit cycle.
- MUX_PISO_PARITY_EN defined: in_data=8'h07 → 8 data bits then parity bit 1 with ser_last=1; in_data=8'h03 → parity bit 0; 9 cycles per word.
